// File: rtl/capture_pkg.sv
// Shared state encoding and framing constants for the capture FIFO drain path.
// Also used by the FIFO fill side, so FIFO_DEPTH lives here.
package capture_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POP    = 3'd1,
      WAIT   = 3'd2,
      HDR_HI = 3'd3,
      HDR_LO = 3'd4,
      SEND   = 3'd5
   } state_t;

   localparam logic [15:0] DEF_SYNC_WORD  = 16'hA55A;
   localparam int          BYTES_PER_WORD = 4;
   localparam int          FIFO_DEPTH     = 10;

   // Byte idx of a word, idx 0 being the most significant byte.
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    word_byte = w[31:24];
         2'd1:    word_byte = w[23:16];
         2'd2:    word_byte = w[15:8];
         default: word_byte = w[7:0];
      endcase
   endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Word buffer to MSB-first byte stream, optionally prefixed by the 2-byte sync header.
// First byte is valid the cycle after i_load; data/valid hold while i_tx_ready is low.
module word_byte_serializer
   import capture_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD
) (
   input  logic        clk2,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_hdr,
   input  logic [31:0] i_word,
   input  logic        i_tx_ready,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   output logic        o_xfer,
   output logic        o_done
);

   logic [31:0] r_buf;
   logic [1:0]  r_idx;
   logic [1:0]  r_hdr;     // 2: high sync byte on the wire, 1: low sync byte, 0: word bytes
   logic        r_tx_vld;
   logic [7:0]  r_tx_dat;
   logic        w_xfer;
   logic        w_last;

   assign w_xfer     = r_tx_vld & i_tx_ready;
   assign w_last     = (r_hdr == 2'd0) && (r_idx == 2'(BYTES_PER_WORD - 1));
   assign o_xfer     = w_xfer;
   assign o_done     = w_xfer & w_last;
   assign o_tx_data  = r_tx_dat;
   assign o_tx_valid = r_tx_vld;

   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         r_buf    <= '0;
         r_idx    <= '0;
         r_hdr    <= '0;
         r_tx_vld <= 1'b0;
         r_tx_dat <= '0;
      end else if (i_load) begin
         r_buf    <= i_word;
         r_idx    <= '0;
         r_tx_vld <= 1'b1;
         if (i_hdr) begin
            r_hdr    <= 2'd2;
            r_tx_dat <= SYNC_WORD[15:8];
         end else begin
            r_hdr    <= 2'd0;
            r_tx_dat <= word_byte(i_word, 2'd0);
         end
      end else if (w_xfer) begin
         case (r_hdr)
            2'd2: begin
               r_hdr    <= 2'd1;
               r_tx_dat <= SYNC_WORD[7:0];
            end
            2'd1: begin
               r_hdr    <= 2'd0;
               r_tx_dat <= word_byte(r_buf, 2'd0);
            end
            default: begin
               if (w_last) begin
                  r_tx_vld <= 1'b0;
               end else begin
                  r_idx    <= r_idx + 2'd1;
                  r_tx_dat <= word_byte(r_buf, r_idx + 2'd1);
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/capture_fifo_reader.sv
// Drains the capture FIFO one word at a time and streams it as bytes with periodic sync headers.
// Pop-to-first-byte is 1+RD_LATENCY cycles (+2 with header); tx_ready low stalls the byte in place.
module capture_fifo_reader
   import capture_pkg::*;
#(
   parameter int          RD_LATENCY  = 1,
   parameter int          FRAME_WORDS = 10,
   parameter logic [15:0] SYNC_WORD   = DEF_SYNC_WORD
) (
   input  logic        clk2,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        fifo_flag,
   output logic        fifo_rd,
   input  logic [31:0] fifo_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        frame_start,
   output logic [15:0] word_count
);

   state_t      r_state;
   logic        r_fifo_rd;
   logic        r_busy;
   logic        r_frame_start;
   logic [15:0] r_word_count;
   logic [7:0]  r_frame_idx;
   logic [1:0]  r_lat;
   logic        w_lat_done;
   logic        w_hdr;
   logic        w_xfer;
   logic        w_done;

   // Counter starts at 0 on the first WAIT cycle, so fifo_data is captured RD_LATENCY cycles after the pop.
   assign w_lat_done = (r_state == WAIT) && (r_lat == 2'(RD_LATENCY - 1));
   assign w_hdr      = (r_frame_idx == 8'd0);

   word_byte_serializer #(
      .SYNC_WORD (SYNC_WORD)
   ) u_ser (
      .clk2       (clk2),
      .rst_n      (rst_n),
      .i_load     (w_lat_done),
      .i_hdr      (w_hdr),
      .i_word     (fifo_data),
      .i_tx_ready (tx_ready),
      .o_tx_data  (tx_data),
      .o_tx_valid (tx_valid),
      .o_xfer     (w_xfer),
      .o_done     (w_done)
   );

   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_fifo_rd     <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_start <= 1'b0;
         r_word_count  <= '0;
         r_frame_idx   <= '0;
         r_lat         <= '0;
      end else begin
         r_fifo_rd     <= 1'b0;
         r_frame_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (enable && fifo_flag) begin
                  r_state   <= POP;
                  r_fifo_rd <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            POP: begin
               r_state <= WAIT;
               r_lat   <= '0;
            end
            WAIT: begin
               if (w_lat_done) r_state <= w_hdr ? HDR_HI : SEND;
               else            r_lat   <= r_lat + 2'd1;
            end
            HDR_HI: begin
               if (w_xfer) begin
                  r_state       <= HDR_LO;
                  r_frame_start <= 1'b1;
               end
            end
            HDR_LO: begin
               if (w_xfer) r_state <= SEND;
            end
            SEND: begin
               if (w_done) begin
                  r_state      <= IDLE;
                  r_busy       <= 1'b0;
                  r_word_count <= r_word_count + 16'd1;
                  r_frame_idx  <= (r_frame_idx == 8'(FRAME_WORDS - 1)) ? 8'd0 : r_frame_idx + 8'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd     = r_fifo_rd;
   assign busy        = r_busy;
   assign frame_start = r_frame_start;
   assign word_count  = r_word_count;

endmodule

// File: tb/tb_capture_fifo_reader.sv
// Directed bench for capture_fifo_reader with a 3-cycle read-latency FIFO model.
// The model drives junk on fifo_data in every cycle except the one the reader must sample.
module tb_capture_fifo_reader;

   localparam int LAT = 3;

   logic        clk2 = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        fifo_flag;
   logic        fifo_rd;
   logic [31:0] fifo_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        frame_start;
   logic [15:0] word_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] words_q [$];
   logic [7:0]  rx_q [$];
   int          rx_cyc [$];
   int          rd_cyc [$];
   int          cyc = 0;
   int          fs_cnt = 0;
   int          rd_cnt = 0;
   int          hold_err = 0;
   int          rd_noflag_err = 0;
   logic        stall_prev = 1'b0;
   logic [7:0]  stall_dat = 8'h00;

   capture_fifo_reader #(
      .RD_LATENCY  (LAT),
      .FRAME_WORDS (10),
      .SYNC_WORD   (16'hA55A)
   ) u_dut (
      .clk2        (clk2),
      .rst_n       (rst_n),
      .enable      (enable),
      .fifo_flag   (fifo_flag),
      .fifo_rd     (fifo_rd),
      .fifo_data   (fifo_data),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .frame_start (frame_start),
      .word_count  (word_count)
   );

   always #5 clk2 = ~clk2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk2);
      #1;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int c = 0;
      while (rx_q.size() < n && c < budget) begin
         step();
         c++;
      end
      check("rx_byte_count", rx_q.size(), n);
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while (busy !== 1'b0 && c < budget) begin
         step();
         c++;
      end
      check("return_to_idle", busy, 1'b0);
   endtask

   task automatic check_stream(input string tag, input logic [7:0] exp_q [$]);
      int errs = 0;
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         if (rx_q[i] !== exp_q[i]) errs++;
      check({tag, "_byte_errs"}, errs, 0);
   endtask

   // FIFO model: pop on fifo_rd, flag drops only after the pop cycle.
   initial begin
      logic [31:0] popped;
      fifo_flag = 1'b0;
      fifo_data = 32'h0;
      forever begin
         step();
         if (fifo_rd === 1'b1) begin
            popped = (words_q.size() != 0) ? words_q.pop_front() : 32'hEEEE_EEEE;
            for (int k = 0; k <= LAT + 1; k++) begin
               if (k > 0) step();
               if (k == 1) fifo_flag = (words_q.size() != 0);
               fifo_data = (k == LAT) ? popped : (32'hBAD0_0000 | 32'(k));
            end
         end else begin
            fifo_flag = (words_q.size() != 0);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk2);
         cyc++;
         if (rst_n === 1'b1) begin
            if (stall_prev && !(tx_valid === 1'b1 && tx_data === stall_dat)) hold_err++;
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
               rx_q.push_back(tx_data);
               rx_cyc.push_back(cyc);
            end
            if (frame_start === 1'b1) fs_cnt++;
            if (fifo_rd === 1'b1) begin
               rd_cnt++;
               rd_cyc.push_back(cyc);
               if (fifo_flag !== 1'b1) rd_noflag_err++;
            end
            stall_prev = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
            stall_dat  = tx_data;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exp_q [$];
      logic [7:0] exp3 [4];
      logic [31:0] w;
      int fs0;
      int rd0;
      int c;

      rst_n    = 1'b0;
      enable   = 1'b0;
      tx_ready = 1'b0;
      repeat (3) step();

      // Reset values
      check("rst_fifo_rd",     fifo_rd,     1'b0);
      check("rst_tx_valid",    tx_valid,    1'b0);
      check("rst_tx_data",     tx_data,     8'h00);
      check("rst_busy",        busy,        1'b0);
      check("rst_frame_start", frame_start, 1'b0);
      check("rst_word_count",  word_count,  16'h0);

      // Single word with header
      rst_n    = 1'b1;
      enable   = 1'b1;
      tx_ready = 1'b1;
      words_q.push_back(32'h11223344);
      wait_rx(6, 100);
      wait_idle(50);
      exp_q = '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
      check_stream("t1_stream", exp_q);
      check("t1_frame_start_cnt", fs_cnt, 1);
      check("t1_rd_cnt", rd_cnt, 1);
      check("t1_word_count", word_count, 16'd1);

      // Fresh frame: 11 words, headers before word 0 and word 10 only
      rst_n = 1'b0;
      step();
      check("t2_rst_word_count", word_count, 16'h0);
      rst_n = 1'b1;
      rx_q.delete();
      rx_cyc.delete();
      rd_cyc.delete();
      fs0 = fs_cnt;
      exp_q.delete();
      for (int i = 0; i <= 10; i++) begin
         w = 32'h10203040 + 32'(i);
         words_q.push_back(w);
         if (i == 0 || i == 10) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h5A);
         end
         exp_q.push_back(w[31:24]);
         exp_q.push_back(w[23:16]);
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
      end
      wait_rx(48, 400);
      wait_idle(50);
      check_stream("t2_stream", exp_q);
      check("t2_frame_start_cnt", fs_cnt - fs0, 2);
      check("t2_word_count", word_count, 16'd11);
      check("t2_rd_pulses", rd_cyc.size(), 11);
      if (rd_cyc.size() == 11) begin
         check("t2_period_hdr", rd_cyc[1] - rd_cyc[0], 11);
         check("t2_period_nohdr", rd_cyc[2] - rd_cyc[1], 9);
         check("t2_period_before_hdr", rd_cyc[10] - rd_cyc[9], 9);
      end

      // Backpressure: each byte stalled 3 cycles, mid-frame so no header
      rx_q.delete();
      tx_ready = 1'b0;
      exp3[0] = 8'hDE;
      exp3[1] = 8'hAD;
      exp3[2] = 8'hBE;
      exp3[3] = 8'hEF;
      words_q.push_back(32'hDEADBEEF);
      for (int b = 0; b < 4; b++) begin
         c = 0;
         while (tx_valid !== 1'b1 && c < 50) begin
            step();
            c++;
         end
         repeat (2) step();
         check("t3_stall_valid", tx_valid, 1'b1);
         check("t3_stall_data", tx_data, exp3[b]);
         tx_ready = 1'b1;
         step();
         tx_ready = 1'b0;
      end
      wait_idle(50);
      tx_ready = 1'b1;
      exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      check_stream("t3_stream", exp_q);
      check("t3_hold_errs", hold_err, 0);
      check("t3_word_count", word_count, 16'd12);

      // Read latency: only the value present exactly LAT cycles after the pop is sent
      rx_q.delete();
      rx_cyc.delete();
      rd_cyc.delete();
      words_q.push_back(32'hCAFEF00D);
      wait_rx(4, 100);
      wait_idle(50);
      exp_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
      check_stream("t4_stream", exp_q);
      if (rd_cyc.size() == 1 && rx_cyc.size() == 4)
         check("t4_rd_to_first_byte", rx_cyc[0] - rd_cyc[0], 4);
      else
         check("t4_rd_pulses", rd_cyc.size(), 1);

      // enable drops during byte 2: word completes, then no pop until enable returns
      rx_q.delete();
      fs0 = fs_cnt;
      words_q.push_back(32'hA1B2C3D4);
      words_q.push_back(32'h01020304);
      c = 0;
      while (rx_q.size() < 1 && c < 100) begin
         step();
         c++;
      end
      enable = 1'b0;
      rd0 = rd_cnt;
      wait_rx(4, 50);
      wait_idle(50);
      repeat (20) step();
      check("t5_no_pop_disabled", rd_cnt - rd0, 0);
      check("t5_busy_disabled", busy, 1'b0);
      check("t5_word_count_mid", word_count, 16'd14);
      enable = 1'b1;
      wait_rx(8, 100);
      wait_idle(50);
      exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
      check_stream("t5_stream", exp_q);
      check("t5_no_header", fs_cnt - fs0, 0);
      check("t5_word_count", word_count, 16'd15);

      // Reset during SEND discards the word; next word opens a fresh frame
      rx_q.delete();
      fs0 = fs_cnt;
      words_q.push_back(32'h55667788);
      wait_rx(2, 100);
      rst_n = 1'b0;
      #1;
      check("t6_rst_tx_valid", tx_valid, 1'b0);
      check("t6_rst_tx_data", tx_data, 8'h00);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_word_count", word_count, 16'h0);
      check("t6_rst_fifo_rd", fifo_rd, 1'b0);
      repeat (2) step();
      rst_n = 1'b1;
      rx_q.delete();
      words_q.push_back(32'h99AABBCC);
      wait_rx(6, 100);
      wait_idle(50);
      exp_q = '{8'hA5, 8'h5A, 8'h99, 8'hAA, 8'hBB, 8'hCC};
      check_stream("t6_stream", exp_q);
      check("t6_frame_start_cnt", fs_cnt - fs0, 1);
      check("t6_word_count", word_count, 16'd1);
      check("rd_without_flag", rd_noflag_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
